// File: rtl/sisc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// sisc_ctrl_fsm
//
// Multi-cycle control sequencer for the SISC datapath. It steps through
// START0/START1/FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the instruction
// register, PC, ALU, register file and data-memory controls. The opcode is
// latched at DECODE and all later decisions use that copy. Memory accesses
// wait on a mem_rdy handshake, guarded by a timeout that raises a sticky fault
// and parks the FSM in HALT. HALT is left only by a resume pulse or by reset.
//
// Opcode map (low 4 bits):
//   0 NOOP   1 LOD   2 STR   3 SWP   4 BRA   5 BRR   6 BNE   7 BNR
//   8 ALU    9..14 unassigned (run as NOOP)    15 HLT
// An opcode with any bit set above bit 3 is illegal.
//
// Build option:
//   ILLEGAL_OP_TRAP_EN  when defined, an illegal opcode seen at DECODE sends
//                       the FSM to HALT and sets fault instead of executing
//                       it as a NOOP.
//
// Parameters:
//   OPCODE_W     opcode width (>= 4)
//   STAT_W       ALU status width, bit0 = Z, then N, C, V
//   MM_W         mode/mask width, mm[MM_W-1] = immediate addressing
//   MEM_TIMEOUT  MEM cycles without mem_rdy before a fault (>= 1)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_f     in   synchronous active-high reset
//   opcode    in   opcode field from the instruction register
//   mm        in   mode/mask field from the instruction register
//   stat      in   registered ALU status flags
//   mem_rdy   in   data memory completion strobe
//   resume    in   leave HALT (one-cycle pulse)
//   ir_load   out  load instruction register
//   pc_write  out  update PC
//   pc_sel    out  0 = PC+1, 1 = branch target
//   br_sel    out  0 = absolute target, 1 = relative target
//   alu_op    out  00 pass, 01 reg-reg, 10 reg-imm, 11 address calc
//   rf_we     out  register file write enable
//   wb_sel    out  0 = ALU result, 1 = memory data
//   mem_req   out  memory access request
//   mem_we    out  memory write
//   halted    out  FSM is in HALT
//   fault     out  sticky fault flag, cleared only by reset
//   state_o   out  present state encoding
// -----------------------------------------------------------------------------
module sisc_ctrl_fsm #(
    parameter int OPCODE_W    = 4,
    parameter int STAT_W      = 4,
    parameter int MM_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [MM_W-1:0]     mm,
    input  logic [STAT_W-1:0]   stat,
    input  logic                mem_rdy,
    input  logic                resume,
    output logic                ir_load,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                br_sel,
    output logic [1:0]          alu_op,
    output logic                rf_we,
    output logic                wb_sel,
    output logic                mem_req,
    output logic                mem_we,
    output logic                halted,
    output logic                fault,
    output logic [2:0]          state_o
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_REG  = 2'b01;
    localparam logic [1:0] ALU_IMM  = 2'b10;
    localparam logic [1:0] ALU_ADDR = 2'b11;

    // Counter holds the number of MEM cycles already spent without mem_rdy,
    // so it never needs to represent MEM_TIMEOUT itself.
    localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                fault_q;

    // -------------------------------------------------------------------------
    // Opcode splitting: only the low nibble is decoded, anything above it
    // marks the opcode illegal.
    // -------------------------------------------------------------------------
    logic [3:0] op_lo;
    logic [3:0] opq_lo;
    logic       op_hi_nz;
    logic       opq_hi_nz;

    assign op_lo  = opcode[3:0];
    assign opq_lo = op_q[3:0];

    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign op_hi_nz  = |opcode[OPCODE_W-1:4];
            assign opq_hi_nz = |op_q[OPCODE_W-1:4];
        end else begin : g_narrow_op
            assign op_hi_nz  = 1'b0;
            assign opq_hi_nz = 1'b0;
        end
    endgenerate

    // Opcode actually executed: an illegal wide opcode degrades to NOOP.
    // With the trap enabled such an opcode never reaches EXECUTE at all.
    logic [3:0] exec_op;
    assign exec_op = opq_hi_nz ? OP_NOOP : opq_lo;

    logic is_lod, is_str, is_swp, is_alu, is_mem, is_branch, is_rel, is_pos;
    assign is_lod    = (exec_op == OP_LOD);
    assign is_str    = (exec_op == OP_STR);
    assign is_swp    = (exec_op == OP_SWP);
    assign is_alu    = (exec_op == OP_ALU);
    assign is_mem    = is_lod || is_str || is_swp;
    assign is_branch = (exec_op == OP_BRA) || (exec_op == OP_BRR) ||
                       (exec_op == OP_BNE) || (exec_op == OP_BNR);
    assign is_rel    = (exec_op == OP_BRR) || (exec_op == OP_BNR);
    // BRA/BRR branch when a masked flag is set, BNE/BNR when none is.
    assign is_pos    = (exec_op == OP_BRA) || (exec_op == OP_BRR);

    // -------------------------------------------------------------------------
    // Branch condition: mm selects which status flags are tested. A narrow
    // mm is zero-extended so the extra flags are simply never selected.
    // -------------------------------------------------------------------------
    logic [STAT_W-1:0] br_mask;

    generate
        if (MM_W >= STAT_W) begin : g_mask_trunc
            assign br_mask = mm[STAT_W-1:0];
        end else begin : g_mask_ext
            assign br_mask = {{(STAT_W - MM_W){1'b0}}, mm};
        end
    endgenerate

    logic br_hit;
    logic br_taken;
    assign br_hit   = |(stat & br_mask);
    assign br_taken = is_pos ? br_hit : !br_hit;

    // -------------------------------------------------------------------------
    // Memory timeout: fires on the MEM cycle that would be the MEM_TIMEOUT-th
    // miss. A mem_rdy on that same cycle completes the access instead.
    // -------------------------------------------------------------------------
    logic tmo_hit;
    assign tmo_hit = (state == S_MEM) && !mem_rdy && (tmo_cnt == TMO_LAST);

    // -------------------------------------------------------------------------
    // DECODE-time halt decision and optional illegal-opcode trap
    // -------------------------------------------------------------------------
    logic dec_halt;
    logic trap_fault;

`ifdef ILLEGAL_OP_TRAP_EN
    logic dec_illegal;
    assign dec_illegal = op_hi_nz || ((op_lo >= 4'd9) && (op_lo <= 4'd14));
    assign dec_halt    = dec_illegal || (op_lo == OP_HLT);
    assign trap_fault  = (state == S_DECODE) && dec_illegal;
`else
    assign dec_halt    = !op_hi_nz && (op_lo == OP_HLT);
    assign trap_fault  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the edge, independent of the
    // order in which the always_ff blocks are evaluated.
    always_ff @(posedge clk) begin : p_state
        if (rst_f) begin
            state <= S_START1;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched opcode, timeout counter and sticky fault.
    always_ff @(posedge clk) begin : p_regs
        if (rst_f) begin
            op_q    <= '0;
            tmo_cnt <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                op_q <= opcode;
            end

            // Counts only consecutive misses inside MEM; any exit clears it.
            if ((state == S_MEM) && !mem_rdy && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (tmo_hit || trap_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin : p_next
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred for a state the case does not mention.
        state_nxt = state;
        case (state)
            S_START0:  state_nxt = S_START1;
            S_START1:  state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_DECODE;
            S_DECODE:  state_nxt = dec_halt ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (is_mem) begin
                    state_nxt = S_MEM;
                end else if (is_alu) begin
                    state_nxt = S_WRITEBACK;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_rdy) begin
                    state_nxt = is_str ? S_FETCH : S_WRITEBACK;
                end else if (tmo_hit) begin
                    state_nxt = S_HALT;
                end
            end
            S_WRITEBACK: state_nxt = S_FETCH;
            S_HALT: begin
                if (resume) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_START1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output decode from present state and latched opcode
    // -------------------------------------------------------------------------
    always_comb begin : p_outputs
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        alu_op   = ALU_PASS;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = 1'b0;
            end
            S_EXECUTE: begin
                if (is_alu) begin
                    alu_op = mm[MM_W-1] ? ALU_IMM : ALU_REG;
                end else if (is_mem) begin
                    alu_op = ALU_ADDR;
                end else if (is_branch && br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = is_rel;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_str;
            end
            S_WRITEBACK: begin
                rf_we  = 1'b1;
                wb_sel = is_lod || is_swp;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault   = fault_q;
    assign state_o = state;

endmodule
